// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: multiply/divide op and state encodings plus decoder constants.
package rv32i_pkg;

   // RV32M operations, encoded exactly as funct3
   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } MDUOp_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } MDUState_e;

   localparam logic [6:0] MDU_OPCODE = 7'b0110011;
   localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/rv32_mdu_step.sv
// One iteration of the multiply/divide datapath on unsigned magnitudes.
// Multiply: {hi,lo} is the product accumulator with the multiplier in lo; opd is the multiplicand.
// Divide:   hi is the partial remainder, lo shifts the dividend out and the quotient in; opd is the divisor.
module rv32_mdu_step #(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1
) (
   input  logic            mode_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] opd,
   output logic [XLEN-1:0] hi_nxt,
   output logic [XLEN-1:0] lo_nxt
);

   localparam int AW = 2*XLEN + MUL_STEP;

   logic [AW-1:0]   acc;
   logic [AW-1:0]   part;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   // Either retire MUL_STEP multiplier bits with shift-add, or produce one restoring-division quotient bit
   always_comb begin
      acc     = '0;
      part    = '0;
      shifted = '0;
      diff    = '0;
      hi_nxt  = hi;
      lo_nxt  = lo;
      if (mode_div) begin
         shifted = {hi, lo[XLEN-1]};
         diff    = shifted - {1'b0, opd};
         if (!diff[XLEN]) begin
            hi_nxt = diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_nxt = shifted[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         acc  = {{MUL_STEP{1'b0}}, hi, lo};
         part = {{MUL_STEP{1'b0}}, opd, {XLEN{1'b0}}};
         for (int i = 0; i < MUL_STEP; i++) begin
            if (lo[i]) acc = acc + (part << i);
         end
         {hi_nxt, lo_nxt} = acc[AW-1:MUL_STEP];
      end
   end

endmodule

// File: rtl/rv32_mdu.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake, tag pass-through and flush.
module rv32_mdu
   import rv32i_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1,
   parameter int TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int CW   = $clog2(XLEN) + 1;
   localparam int KMUL = XLEN / MUL_STEP;

   MDUState_e        state_q, state_d;
   MDUOp_e           op_q, op_d, op_in;
   logic             neg_q, neg_d;
   logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_result_q, out_result_d;

   logic             accept, is_div, a_signed, b_signed, a_neg, b_neg;
   logic             div_zero, div_ovf;
   logic [XLEN-1:0]  a_mag, b_mag, special_res, step_hi, step_lo;
   logic [2*XLEN-1:0] prod_fix;

   // Two's-complement negate when the sign flag is set
   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   rv32_mdu_step #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) u_step (
      .mode_div (op_q[2]),
      .hi       (hi_q),
      .lo       (lo_q),
      .opd      (opd_q),
      .hi_nxt   (step_hi),
      .lo_nxt   (step_lo)
   );

   assign in_ready   = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_tag    = tag_q;

   // Next-state, datapath and output computation; flush overrides everything else
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      neg_d        = neg_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      opd_d        = opd_q;
      cnt_d        = cnt_q;
      tag_d        = tag_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;

      op_in    = MDUOp_e'(in_op);
      is_div   = in_op[2];
      accept   = in_valid && in_ready;
      a_signed = (op_in == MDU_MUL) || (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
                 (op_in == MDU_DIV) || (op_in == MDU_REM);
      b_signed = (op_in == MDU_MUL) || (op_in == MDU_MULH) ||
                 (op_in == MDU_DIV) || (op_in == MDU_REM);
      a_neg    = a_signed && in_a[XLEN-1];
      b_neg    = b_signed && in_b[XLEN-1];
      a_mag    = cond_neg(in_a, a_neg);
      b_mag    = cond_neg(in_b, b_neg);
      div_zero = is_div && (in_b == '0);
      div_ovf  = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                 (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
      if (div_zero) special_res = in_op[1] ? in_a : '1;
      else          special_res = in_op[1] ? '0 : in_a;
      prod_fix = cond_neg2({hi_q, lo_q}, neg_q);

      case (state_q)
         CALC: begin
            hi_d = step_hi;
            lo_d = step_lo;
            if (cnt_q == '0) state_d = FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         FIX: begin
            case (op_q)
               MDU_MUL:                          out_result_d = prod_fix[XLEN-1:0];
               MDU_MULH, MDU_MULHSU, MDU_MULHU:  out_result_d = prod_fix[2*XLEN-1:XLEN];
               MDU_DIV, MDU_DIVU:                out_result_d = cond_neg(lo_q, neg_q);
               default:                          out_result_d = cond_neg(hi_q, neg_q);
            endcase
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: ;
      endcase

      if (accept) begin
         op_d  = op_in;
         tag_d = in_tag;
         hi_d  = '0;
         if (is_div) begin
            lo_d  = a_mag;
            opd_d = b_mag;
            neg_d = in_op[1] ? a_neg : (a_neg ^ b_neg);
            cnt_d = CW'(XLEN - 1);
         end else begin
            lo_d  = b_mag;
            opd_d = a_mag;
            neg_d = a_neg ^ b_neg;
            cnt_d = CW'(KMUL - 1);
         end
         if (div_zero || div_ovf) begin
            out_result_d = special_res;
            out_valid_d  = 1'b1;
            state_d      = DONE;
         end else begin
            out_valid_d = 1'b0;
            state_d     = CALC;
         end
      end

      if (flush) begin
         out_valid_d = 1'b0;
         state_d     = IDLE;
      end
   end

   // State and datapath registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_q         <= MDU_MUL;
         neg_q        <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
         opd_q        <= '0;
         cnt_q        <= '0;
         tag_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         neg_q        <= neg_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         opd_q        <= opd_d;
         cnt_q        <= cnt_d;
         tag_q        <= tag_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
      end
   end

endmodule

// File: tb/tb_rv32_mdu.sv
// Scoreboard bench for rv32_mdu: directed RV32M vectors, specials, hold/back-to-back, flush and reset.
module tb_rv32_mdu;
   import rv32i_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [2:0]  in_op = '0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [4:0]  in_tag = '0;
   logic        in_ready, out_valid;
   logic [31:0] out_result;
   logic [4:0]  out_tag;

   logic        in4_valid = 1'b0;
   logic [2:0]  in4_op = '0;
   logic [31:0] in4_a = '0;
   logic [31:0] in4_b = '0;
   logic        in4_ready, out4_valid;
   logic [31:0] out4_result;
   logic [4:0]  out4_tag;

   rv32_mdu #(.XLEN(32), .MUL_STEP(1), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
   );

   rv32_mdu #(.XLEN(32), .MUL_STEP(4), .TAG_W(5)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(in4_valid), .in_ready(in4_ready),
      .in_op(in4_op), .in_a(in4_a), .in_b(in4_b), .in_tag(5'd3), .out_valid(out4_valid),
      .out_ready(1'b1), .out_result(out4_result), .out_tag(out4_tag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          lat;
   } vec_t;
   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int lat,
                        input bit push, input logic rdy);
      int n = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_tag    = tag;
      out_ready = rdy;
      #1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("accept", {31'b0, in_ready}, 32'd1);
      if (in_ready && push) sb.push_back('{res: exp, tag: tag, due: cyc + lat});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 32'd0);
      @(negedge clk);
   endtask

   // Monitor: compares each handshaken result against the oldest expectation
   initial begin : monitor
      bit   seen;
      int   first;
      exp_t e;
      seen  = 1'b0;
      first = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            seen = 1'b0;
         end else if (out_valid) begin
            if (!seen) begin
               seen  = 1'b1;
               first = cyc;
            end
            if (out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_output: result 0x%08h tag %0d with nothing outstanding (cycle %0d)",
                           out_result, out_tag, cyc);
               end else begin
                  e = sb.pop_front();
                  check("result", out_result, e.res);
                  check("tag", {27'b0, out_tag}, {27'b0, e.tag});
                  check("latency", first, e.due);
               end
               seen = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int c0, n;
      vecs = '{
         '{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
         '{3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,       34},
         '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
         '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
         '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
         '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34},
         '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34},
         '{3'd5, 32'd100,      32'd7,         32'd14,        34},
         '{3'd7, 32'd100,      32'd7,         32'd2,         34},
         '{3'd4, 32'd5,        32'd0,         32'hFFFF_FFFF, 1},
         '{3'd7, 32'd5,        32'd0,         32'd5,         1},
         '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
         '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1}
      };

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_tag", {27'b0, out_tag}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, including the latency-1 specials
      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].r, vecs[i].lat, 1'b1, 1'b1);
         wait_idle();
      end

      // Hold in DONE with out_ready low, then back-to-back accept on release
      issue(MDU_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, 34, 1'b1, 1'b0);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("hold_reach_done", {31'b0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check("hold_out_valid", {31'b0, out_valid}, 32'd1);
         check("hold_out_result", out_result, 32'd14);
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      issue(MDU_REMU, 32'd100, 32'd7, 5'd21, 32'd2, 34, 1'b1, 1'b1);
      wait_idle();

      // MUL_STEP=4 instance: same product in 10 cycles
      @(negedge clk);
      in4_valid = 1'b1;
      in4_op    = MDU_MUL;
      in4_a     = 32'd7;
      in4_b     = 32'hFFFF_FFFD;
      #1;
      check("mul4_accept", {31'b0, in4_ready}, 32'd1);
      c0 = cyc;
      @(posedge clk);
      #1;
      in4_valid = 1'b0;
      n = 0;
      while (!out4_valid && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("mul4_latency", cyc - c0, 32'd10);
      check("mul4_result", out4_result, 32'hFFFF_FFEB);
      check("mul4_tag", {27'b0, out4_tag}, 32'd3);

      // Flush in CALC cycle 10: no result, ready again next cycle
      issue(MDU_DIVU, 32'd100, 32'd7, 5'd25, 32'd0, 34, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_in_ready_low", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      #1;
      check("flush_out_valid", {31'b0, out_valid}, 32'd0);
      check("flush_in_ready", {31'b0, in_ready}, 32'd1);
      repeat (45) @(negedge clk);

      // Asynchronous reset mid-CALC
      issue(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd26, 32'd0, 34, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check("arst_in_ready", {31'b0, in_ready}, 32'd1);
      check("arst_out_result", out_result, 32'd0);
      check("arst_out_tag", {27'b0, out_tag}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (45) @(negedge clk);
      check("final_queue", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
